// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
// Four-source prioritised interrupt controller for a small soft CPU.
// External sources are synchronised and rising-edge detected into PEND,
// qualified by MASK and the global enable, and presented to the control unit
// as a registered request with the index of the highest-priority source.
//
// Ports
//   CLK       in   1  system clock, all state on rising edge
//   RST       in   1  synchronous active-high reset
//   IRQ_IN    in   4  asynchronous interrupt sources, bit 0 highest priority
//   I_SET     in   1  global enable set (SEI / RETIE)
//   I_CLR     in   1  global enable clear (CLI)
//   INT_ACK   in   1  one-cycle acknowledge on entering the interrupt cycle
//   IO_STRB   in   1  output-port write strobe
//   PORT_ID   in   8  port address (0x20 = MASK, 0x21 = PEND write-1-to-clear)
//   OUT_PORT  in   8  port write data
//   INTERRUPT out  1  registered interrupt request
//   INT_ID    out  2  index of source requested or being serviced
//   STATUS    out  8  {MASK, PEND}
//   I_EN      out  1  global interrupt enable flag
// -----------------------------------------------------------------------------
module interrupt_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] IRQ_IN,
  input  logic       I_SET,
  input  logic       I_CLR,
  input  logic       INT_ACK,
  input  logic       IO_STRB,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  output logic       INTERRUPT,
  output logic [1:0] INT_ID,
  output logic [7:0] STATUS,
  output logic       I_EN
);

  localparam logic [7:0] PORT_MASK = 8'h20;
  localparam logic [7:0] PORT_W1C  = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Lowest set index wins; an all-zero vector is never consumed by callers.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] mask_q, mask_d;
  logic       ien_q, ien_d;
  logic       int_q, int_d;
  logic [1:0] int_id_q, int_id_d;
  state_e     state_q, state_d;

  logic [3:0] edge_s;
  logic [3:0] elig_s;
  logic [1:0] sel_s;
  logic [3:0] w1c_s;
  logic [3:0] ack_clr_s;

  // A level that was already high before the synchroniser saw it low is not an edge.
  assign edge_s = sync2_q & ~prev_q;
  assign elig_s = pend_q & mask_q;
  assign sel_s  = lowest_idx(elig_s);
  assign w1c_s  = (IO_STRB && (PORT_ID == PORT_W1C)) ? OUT_PORT[3:0] : 4'b0000;

  // Request state machine: next state, request flag and serviced index.
  always_comb begin
    state_d   = state_q;
    int_d     = int_q;
    int_id_d  = int_id_q;
    ack_clr_s = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        // An acknowledge seen here only drops the global enable.
        if (ien_q && (elig_s != 4'b0000) && !INT_ACK) begin
          state_d  = ST_REQ;
          int_d    = 1'b1;
          int_id_d = sel_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (INT_ACK) begin
          state_d   = ST_SERVICE;
          int_d     = 1'b0;
          ack_clr_s = 4'b0001 << int_id_q;
        end else if (I_CLR || (elig_s == 4'b0000)) begin
          state_d = ST_IDLE;
          int_d   = 1'b0;
        end else begin
          // Follow the selector so a newer higher-priority source pre-empts.
          int_id_d = sel_s;
        end
      end
      ST_SERVICE: begin
        int_d = 1'b0;
        if (I_SET) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // Pending, mask and enable next-state; new edges override any clear.
  always_comb begin
    pend_d = (pend_q & ~(w1c_s | ack_clr_s)) | edge_s;
    if (IO_STRB && (PORT_ID == PORT_MASK)) begin
      mask_d = OUT_PORT[3:0];
    end else begin
      mask_d = mask_q;
    end
    if (I_CLR || INT_ACK) begin
      ien_d = 1'b0;
    end else if (I_SET) begin
      ien_d = 1'b1;
    end else begin
      ien_d = ien_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      prev_q   <= 4'b0000;
      pend_q   <= 4'b0000;
      mask_q   <= 4'b0000;
      ien_q    <= 1'b0;
      int_q    <= 1'b0;
      int_id_q <= 2'd0;
      state_q  <= ST_IDLE;
    end else begin
      sync1_q  <= IRQ_IN;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      ien_q    <= ien_d;
      int_q    <= int_d;
      int_id_q <= int_id_d;
      state_q  <= state_d;
    end
  end

  assign INTERRUPT = int_q;
  assign INT_ID    = int_id_q;
  assign STATUS    = {mask_q, pend_q};
  assign I_EN      = ien_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] irq;
  logic       i_set, i_clr, int_ack, io_strb;
  logic [7:0] port_id, out_port;
  logic       interrupt;
  logic [1:0] int_id;
  logic [7:0] status;
  logic       i_en;

  interrupt_ctrl dut (
    .CLK(clk), .RST(rst), .IRQ_IN(irq), .I_SET(i_set), .I_CLR(i_clr),
    .INT_ACK(int_ack), .IO_STRB(io_strb), .PORT_ID(port_id), .OUT_PORT(out_port),
    .INTERRUPT(interrupt), .INT_ID(int_id), .STATUS(status), .I_EN(i_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       intr;
    logic [1:0] id;
    logic [7:0] stat;
    logic       ien;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  int         m_mode;
  logic       m_intr;
  int         m_id;
  logic [3:0] m_pend, m_mask;
  logic       m_ien;
  // hist[k] = IRQ level sampled k+1 edges before the coming edge
  logic [3:0] hist [3];

  task automatic model_update();
    logic [3:0] elig, clr_bits, newly, w1c;
    int sel;
    if (rst) begin
      m_mode = M_IDLE; m_intr = 1'b0; m_id = 0;
      m_pend = 4'd0; m_mask = 4'd0; m_ien = 1'b0;
      for (int k = 0; k < 3; k++) hist[k] = 4'd0;
    end else begin
      elig = m_pend & m_mask;
      sel = 0;
      for (int b = 3; b >= 0; b--) if (elig[b]) sel = b;
      clr_bits = 4'd0;
      if (m_mode == M_IDLE) begin
        if (m_ien && elig != 4'd0 && !int_ack) begin
          m_mode = M_REQ; m_intr = 1'b1; m_id = sel;
        end
      end else if (m_mode == M_REQ) begin
        if (int_ack) begin
          m_mode = M_SVC; m_intr = 1'b0; clr_bits[m_id] = 1'b1;
        end else if (i_clr || elig == 4'd0) begin
          m_mode = M_IDLE; m_intr = 1'b0;
        end else begin
          m_id = sel;
        end
      end else begin
        if (i_set) m_mode = M_IDLE;
      end
      // rising edge seen two samples back becomes pending now
      newly = hist[1] & ~hist[2];
      w1c = (io_strb && port_id == 8'h21) ? out_port[3:0] : 4'd0;
      m_pend = (m_pend & ~(w1c | clr_bits)) | newly;
      if (io_strb && port_id == 8'h20) m_mask = out_port[3:0];
      if (i_clr || int_ack) m_ien = 1'b0;
      else if (i_set) m_ien = 1'b1;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq;
    end
  endtask

  // Apply the currently set inputs for one clock and queue the expectation.
  task automatic step();
    exp_t e;
    model_update();
    e.intr = m_intr; e.id = m_id[1:0]; e.stat = {m_mask, m_pend}; e.ien = m_ien;
    sb_q.push_back(e);
    @(negedge clk);
    rst = 1'b0; i_set = 1'b0; i_clr = 1'b0; int_ack = 1'b0; io_strb = 1'b0;
    port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    io_strb = 1'b1; port_id = p; out_port = d;
    step();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({interrupt, int_id, status, i_en} !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got intr=%b id=%0d status=%h ien=%b, want intr=%b id=%0d status=%h ien=%b",
                   $time, interrupt, int_id, status, i_en, e.intr, e.id, e.stat, e.ien);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; irq = 4'd0; i_set = 1'b0; i_clr = 1'b0; int_ack = 1'b0;
    io_strb = 1'b0; port_id = 8'h00; out_port = 8'h00;
    step();
    rst = 1'b1; step();
    idle(1);

    // basic request on source 0
    wr(8'h20, 8'h01);
    i_set = 1'b1; step();
    irq = 4'b0001; step();
    irq = 4'b0000; idle(5);
    int_ack = 1'b1; step();
    idle(2);

    // priority: sources 3 and 1 together
    wr(8'h20, 8'h0F);
    i_set = 1'b1; step();
    irq = 4'b1010; step();
    idle(5);
    int_ack = 1'b1; step();
    idle(1);
    i_set = 1'b1; step();
    idle(3);
    int_ack = 1'b1; step();
    i_set = 1'b1; step();
    irq = 4'b0000; idle(3);

    // masking and global enable
    wr(8'h21, 8'h0F);
    wr(8'h20, 8'h00);
    i_clr = 1'b1; step();
    irq = 4'b0100; step();
    irq = 4'b0000; idle(4);
    wr(8'h20, 8'h04);
    idle(2);
    i_set = 1'b1; step();
    idle(2);
    int_ack = 1'b1; step();
    i_set = 1'b1; step();
    idle(2);

    // withdraw while requesting
    wr(8'h20, 8'h01);
    i_set = 1'b1; step();
    irq = 4'b0001; step();
    irq = 4'b0000; idle(4);
    i_clr = 1'b1; step();
    idle(2);
    i_set = 1'b1; step();
    idle(2);
    int_ack = 1'b1; step();
    i_set = 1'b1; step();
    idle(2);

    // simultaneous edge/clear and set/clear
    i_clr = 1'b1; step();
    irq = 4'b0001; step();
    step();
    wr(8'h21, 8'h01);
    irq = 4'b0000; i_set = 1'b1; i_clr = 1'b1; step();
    idle(2);

    // reset while servicing with PEND = 0x6
    wr(8'h21, 8'h0F);
    wr(8'h20, 8'h0F);
    i_set = 1'b1; step();
    irq = 4'b0110; step();
    irq = 4'b0000; idle(4);
    int_ack = 1'b1; step();
    irq = 4'b0010; step();
    irq = 4'b0000; idle(3);
    rst = 1'b1; step();
    idle(2);

    // source held high across reset release
    irq = 4'b1000; step();
    idle(3);
    rst = 1'b1; step();
    idle(4);
    irq = 4'b0000; idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      if ($urandom_range(0, 5) == 0) begin
        io_strb = 1'b1;
        case ($urandom_range(0, 3))
          0, 3:    port_id = 8'h20;
          1:       port_id = 8'h21;
          default: port_id = 8'($urandom_range(0, 255));
        endcase
        out_port = 8'($urandom_range(0, 255));
      end
      i_set = ($urandom_range(0, 4) == 0);
      i_clr = ($urandom_range(0, 9) == 0);
      if (m_mode == M_REQ) int_ack = ($urandom_range(0, 2) == 0);
      else                 int_ack = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
